l2_cache_param: RTL and testbench
=================================

# l2_cache_param

Parametrised, write-back, write-allocate, N-way set-associative L2 cache sitting between the cache arbiter and physical memory. It generalises the fixed-geometry L2 with configurable way count, set count and line width. It adds tree pseudo-LRU replacement for any power-of-two associativity, a registered request capture stage, and synchronous reset that invalidates every line. Line-granular transfers only; hit/miss pulses feed the performance counters.

## Interface
Parameters:
- WAYS, 4, associativity; power of two, ≥2
- SETS, 8, number of sets; power of two, ≥2
- ADDR_W, 16, address width
- LINE_W, 128, cacheline width in bits; OFFS = log2(LINE_W/8), IDX = log2(SETS), TAG = ADDR_W-IDX-OFFS

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- mem_read  in  1  arbiter read request, held until mem_resp
- mem_write  in  1  arbiter write request, held until mem_resp; never with mem_read
- mem_address  in  ADDR_W  request byte address; offset bits ignored
- mem_wdata  in  LINE_W  full-line write data
- mem_resp  out  1  one-cycle completion pulse
- mem_rdata  out  LINE_W  read data, valid while mem_resp=1
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_address  out  ADDR_W  line-aligned address (offset bits 0)
- pmem_wdata  out  LINE_W  writeback data
- pmem_resp  in  1  memory completion pulse
- pmem_rdata  in  LINE_W  fill data, valid with pmem_resp
- eviction  out  1  high throughout a dirty writeback
- l2hits_inc  out  1  one-cycle pulse per first-lookup hit
- l2misses_inc  out  1  one-cycle pulse per miss

## Operation
- Per set, per way: valid, dirty, TAG-bit tag, LINE_W data. Per set: WAYS-1 tree-PLRU bits.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL.
- IDLE: on mem_read|mem_write, register address, wdata, op, then go to LOOKUP; clear the refill flag.
- LOOKUP: tag compare across all valid ways of set addr[OFFS+IDX-1:OFFS].
  - Hit: mem_resp=1. Read drives mem_rdata = hit line. Write replaces the whole line and sets dirty=1. PLRU path points away from the hit way. l2hits_inc=1 unless the refill flag is set. Go to IDLE.
  - Miss: l2misses_inc=1. Victim = lowest-index invalid way, else the PLRU victim. Dirty victim goes to WRITEBACK; otherwise go to FILL. Victim index is registered.
- WRITEBACK: pmem_write=1, eviction=1, pmem_address={victim tag, index, 0}, pmem_wdata=victim line. On pmem_resp go to FILL.
- FILL: pmem_read=1, pmem_address={req tag, index, 0}. On pmem_resp, write pmem_rdata into the victim way with valid=1, dirty=0 and the new tag. Set the refill flag and go to LOOKUP, which now hits. A write miss therefore completes as a write hit (write-allocate).
- PLRU updated only on hits, including the post-fill hit.
- Reset: all valid, dirty and PLRU bits cleared; FSM to IDLE; the registered request is dropped. Tag/data arrays are not reset.

## Timing
- All outputs are 0 during reset and in IDLE.
- Request sampled at edge E0. LOOKUP occupies the cycle after E0. Hit latency: mem_resp in the 2nd cycle of request assertion.
- Arbiter deasserts the request at the edge ending the mem_resp cycle. IDLE samples again on the next edge, so no double capture.
- Clean miss: LOOKUP(1) + FILL(≥1, until pmem_resp) + LOOKUP(1).
- Dirty miss: adds WRITEBACK(≥1) before FILL.
- pmem_read/pmem_write are held stable with a constant address until the pmem_resp cycle. They drop the cycle after pmem_resp.
- Reset asserted mid-WRITEBACK/FILL: pmem_read/pmem_write/eviction are 0 the cycle after the reset edge; any pending pmem_resp is ignored.
- mem_address changing while a request is in flight has no effect (registered copy used).
- l2hits_inc and l2misses_inc are never both 1; each is at most one pulse per request.

## Test plan
Default parameters. Set-0 addresses are 0x0000, 0x0080, 0x0100, 0x0180, 0x0200.
- Cold read 0x0000, memory returns line A → pmem_read at 0x0000, l2misses_inc one pulse, mem_rdata=A, no l2hits_inc, eviction=0.
- Re-read 0x0000 → mem_resp in 2nd cycle, l2hits_inc=1, no pmem activity.
- Write B to 0x0080 (miss) → fill at 0x0080 then line=B dirty. Read 0x0080 → B with no pmem access.
- Fill ways with 0x0000, 0x0080, 0x0100, 0x0180. Read 0x0000 again, then read 0x0200 → PLRU victim is not 0x0000. If the victim is dirty 0x0080, expect pmem_write at 0x0080 with data B and eviction=1, then pmem_read at 0x0200.
- Assert rst during FILL → pmem_read low next cycle. Next read of 0x0000 misses (all lines invalid).
- Delay pmem_resp by 20 cycles → pmem_read/address stable all 20 cycles, mem_resp exactly once.

Source files
------------

// File: rtl/l2_cache_param.sv
`default_nettype none
// ============================================================================
// Module  : l2_cache_param
// Purpose : Write-back, write-allocate N-way set-associative L2 with tree PLRU.
// Rev     : 1.0  initial release
// ============================================================================
module l2_cache_param #(
  parameter int WAYS   = 4,
  parameter int SETS   = 8,
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic              mem_resp,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic              eviction,
  output logic              l2hits_inc,
  output logic              l2misses_inc
);

  localparam int OFFS  = $clog2(LINE_W / 8);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG   = ADDR_W - IDX - OFFS;
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOOKUP    = 2'd1,
    S_WRITEBACK = 2'd2,
    S_FILL      = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              refill_q, refill_d;
  logic [WAY_W-1:0]  victim_q, victim_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAYS-2:0]   plru_q  [SETS];
  logic [TAG-1:0]    tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  logic [IDX-1:0]    w_idx;
  logic [TAG-1:0]    w_tag;
  logic [WAYS-1:0]   w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic [WAY_W-1:0]  w_inv_way;
  logic              w_inv_found;
  logic [WAYS-2:0]   w_plru_cur;
  logic [WAYS-2:0]   w_plru_upd;
  logic [WAY_W-1:0]  w_plru_vic;
  logic [WAY_W-1:0]  w_victim_sel;
  logic              w_capture;
  logic              w_hit_we;
  logic              w_fill_we;

  assign w_idx = addr_q[OFFS +: IDX];
  assign w_tag = addr_q[OFFS+IDX +: TAG];

  for (genvar w = 0; w < WAYS; w++) begin : g_hit
    assign w_hit[w] = valid_q[w_idx][w] && (tag_q[w_idx][w] == w_tag);
  end

  always_comb begin
    w_hit_way   = '0;
    w_inv_way   = '0;
    w_inv_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_hit[w]) w_hit_way = WAY_W'(w);
      if (!w_inv_found && !valid_q[w_idx][w]) begin
        w_inv_way   = WAY_W'(w);
        w_inv_found = 1'b1;
      end
    end
  end

  // Heap-ordered tree: node n has children 2n+1 (bit 0, lower half) and 2n+2.
  always_comb begin
    int node;
    w_plru_cur = plru_q[w_idx];
    w_plru_upd = w_plru_cur;
    w_plru_vic = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      w_plru_vic[WAY_W-1-l] = w_plru_cur[node];
      node = 2 * node + 1 + int'(w_plru_cur[node]);
    end
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      w_plru_upd[node] = ~w_hit_way[WAY_W-1-l];
      node = 2 * node + 1 + int'(w_hit_way[WAY_W-1-l]);
    end
  end

  assign w_victim_sel = w_inv_found ? w_inv_way : w_plru_vic;

  always_comb begin
    state_d      = state_q;
    refill_d     = refill_q;
    victim_d     = victim_q;
    w_capture    = 1'b0;
    w_hit_we     = 1'b0;
    w_fill_we    = 1'b0;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    eviction     = 1'b0;
    l2hits_inc   = 1'b0;
    l2misses_inc = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (mem_read || mem_write) begin
            w_capture = 1'b1;
            refill_d  = 1'b0;
            state_d   = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (|w_hit) begin
            mem_resp   = 1'b1;
            w_hit_we   = 1'b1;
            l2hits_inc = !refill_q;
            if (!write_q) mem_rdata = data_q[w_idx][w_hit_way];
            state_d    = S_IDLE;
          end else begin
            l2misses_inc = 1'b1;
            victim_d     = w_victim_sel;
            if (valid_q[w_idx][w_victim_sel] && dirty_q[w_idx][w_victim_sel])
              state_d = S_WRITEBACK;
            else
              state_d = S_FILL;
          end
        end
        S_WRITEBACK: begin
          pmem_write   = 1'b1;
          eviction     = 1'b1;
          pmem_address = {tag_q[w_idx][victim_q], w_idx, {OFFS{1'b0}}};
          pmem_wdata   = data_q[w_idx][victim_q];
          if (pmem_resp) state_d = S_FILL;
        end
        S_FILL: begin
          pmem_read    = 1'b1;
          pmem_address = {w_tag, w_idx, {OFFS{1'b0}}};
          if (pmem_resp) begin
            w_fill_we = 1'b1;
            refill_d  = 1'b1;
            state_d   = S_LOOKUP;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      refill_q <= 1'b0;
      victim_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      refill_q <= refill_d;
      victim_q <= victim_d;
      if (w_capture) begin
        addr_q  <= mem_address;
        wdata_q <= mem_wdata;
        write_q <= mem_write;
      end
      if (w_hit_we) begin
        plru_q[w_idx] <= w_plru_upd;
        if (write_q) dirty_q[w_idx][w_hit_way] <= 1'b1;
      end
      if (w_fill_we) begin
        valid_q[w_idx][victim_q] <= 1'b1;
        dirty_q[w_idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_hit_we && write_q) data_q[w_idx][w_hit_way] <= wdata_q;
    if (w_fill_we) begin
      data_q[w_idx][victim_q] <= pmem_rdata;
      tag_q[w_idx][victim_q]  <= w_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_cache_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_l2_cache_param
// Purpose : Self-checking bench for l2_cache_param with a backing-memory model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_l2_cache_param;

  logic         clk;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_resp;
  logic [127:0] mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         eviction;
  logic         l2hits_inc;
  logic         l2misses_inc;

  l2_cache_param #(.WAYS(4), .SETS(8), .ADDR_W(16), .LINE_W(128)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .eviction     (eviction),
    .l2hits_inc   (l2hits_inc),
    .l2misses_inc (l2misses_inc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] exp;
  } exp_t;

  exp_t         sbq[$];
  logic [127:0] ref_mem   [logic [15:0]];
  logic [127:0] pmem_store[logic [15:0]];

  int n_checks = 0;
  int n_pass   = 0;
  int resp_delay = 0;

  int          n_hit, n_miss, n_resp, n_evict, n_both;
  int          n_pr_cyc, n_pr_start, n_pw_cyc, n_pw_start, n_stab;
  logic [15:0] pr_addr, pw_addr;
  logic [127:0] pw_data;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] init_line(input logic [15:0] a);
    return {8{a ^ 16'hC3A5}};
  endfunction

  function automatic logic [127:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_line(a);
  endfunction

  function automatic logic [127:0] pmem_rd(input logic [15:0] a);
    if (pmem_store.exists(a)) return pmem_store[a];
    return init_line(a);
  endfunction

  task automatic clear_mon();
    n_hit = 0; n_miss = 0; n_resp = 0; n_evict = 0;
    n_pr_cyc = 0; n_pr_start = 0; n_pw_cyc = 0; n_pw_start = 0; n_stab = 0;
    pr_addr = '0; pw_addr = '0; pw_data = '0;
  endtask

  // Physical memory: answers after resp_delay extra cycles of a held request.
  initial begin : responder
    int wait_cnt;
    wait_cnt   = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!rst && (pmem_read || pmem_write)) begin
        wait_cnt++;
        if (wait_cnt > resp_delay) begin
          wait_cnt  = 0;
          pmem_resp = 1'b1;
          if (pmem_read) pmem_rdata = pmem_rd(pmem_address);
          else pmem_store[pmem_address] = pmem_wdata;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Observes DUT outputs mid-cycle and retires scoreboard entries on mem_resp.
  initial begin : monitor
    exp_t        e;
    logic        prev_pr, prev_pw;
    logic [15:0] prev_addr;
    prev_pr = 1'b0; prev_pw = 1'b0; prev_addr = '0;
    n_both = 0;
    clear_mon();
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pr = 1'b0;
        prev_pw = 1'b0;
      end else begin
        if (l2hits_inc) n_hit++;
        if (l2misses_inc) n_miss++;
        if (l2hits_inc && l2misses_inc) n_both++;
        if (eviction) n_evict++;
        if (pmem_read) begin
          n_pr_cyc++;
          if (!prev_pr) begin n_pr_start++; pr_addr = pmem_address; end
          else if (pmem_address != prev_addr) n_stab++;
        end
        if (pmem_write) begin
          n_pw_cyc++;
          if (!prev_pw) begin n_pw_start++; pw_addr = pmem_address; pw_data = pmem_wdata; end
          else if (pmem_address != prev_addr) n_stab++;
        end
        if (mem_resp) begin
          n_resp++;
          if (sbq.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sbq.pop_front();
            if (!e.wr) chk("rdata", mem_rdata, e.exp);
          end
        end
        prev_pr   = pmem_read;
        prev_pw   = pmem_write;
        prev_addr = pmem_address;
      end
    end
  end

  task automatic do_req(input logic wr, input logic [15:0] a, input logic [127:0] d, output int lat);
    exp_t        e;
    logic [15:0] la;
    la     = a & 16'hFFF0;
    e.wr   = wr;
    e.addr = la;
    if (wr) begin
      ref_mem[la] = d;
      e.exp = d;
    end else begin
      e.exp = ref_rd(la);
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    mem_read    = !wr;
    mem_write   = wr;
    mem_address = a;
    mem_wdata   = d;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 2) mem_address = 16'($urandom);
      if (mem_resp) begin lat = k; break; end
    end
    if (lat == 0) chk("resp_timeout", 0, 1);
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  localparam logic [127:0] DATA_B = {4{32'hB0B0_0080}};
  localparam logic [127:0] DATA_C = {4{32'hC0C0_0100}};
  localparam logic [127:0] DATA_D = {4{32'hD0D0_0180}};

  initial begin : stim
    int          lat;
    logic        seen;
    logic [15:0] victim;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_mem_resp", mem_resp, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {mem_resp, pmem_read, pmem_write, eviction, l2hits_inc, l2misses_inc}, 0);
    chk("idle_addr", pmem_address, 0);

    // Cold read miss
    clear_mon();
    do_req(1'b0, 16'h0000, '0, lat);
    chk("cold_lat", lat, 4);
    chk("cold_miss", n_miss, 1);
    chk("cold_hit", n_hit, 0);
    chk("cold_fill_cnt", n_pr_start, 1);
    chk("cold_fill_addr", pr_addr, 16'h0000);
    chk("cold_evict", n_evict, 0);

    // Re-read hits in the second cycle
    clear_mon();
    do_req(1'b0, 16'h0004, '0, lat);
    chk("hit_lat", lat, 2);
    chk("hit_cnt", n_hit, 1);
    chk("hit_miss", n_miss, 0);
    chk("hit_pmem", n_pr_start + n_pw_start, 0);

    // Write miss allocates, then reads back from cache
    clear_mon();
    do_req(1'b1, 16'h0080, DATA_B, lat);
    chk("wmiss_miss", n_miss, 1);
    chk("wmiss_hit", n_hit, 0);
    chk("wmiss_fill_addr", pr_addr, 16'h0080);
    chk("wmiss_wb", n_pw_start, 0);
    clear_mon();
    do_req(1'b0, 16'h0080, '0, lat);
    chk("rb_hit", n_hit, 1);
    chk("rb_pmem", n_pr_start + n_pw_start, 0);

    // Fill remaining ways dirty, touch 0x0000, then force a dirty eviction
    do_req(1'b1, 16'h0100, DATA_C, lat);
    do_req(1'b1, 16'h0180, DATA_D, lat);
    do_req(1'b0, 16'h0000, '0, lat);
    clear_mon();
    do_req(1'b0, 16'h0200, '0, lat);
    victim = pw_addr;
    chk("evict_wb_cnt", n_pw_start, 1);
    chk("evict_cycles", n_evict, n_pw_cyc);
    chk("evict_not_mru", (victim == 16'h0080) || (victim == 16'h0100) || (victim == 16'h0180), 1);
    chk("evict_wb_data", pw_data, ref_rd(victim));
    chk("evict_fill_addr", pr_addr, 16'h0200);
    chk("evict_miss", n_miss, 1);
    clear_mon();
    do_req(1'b0, 16'h0000, '0, lat);
    chk("mru_kept", n_miss, 0);
    clear_mon();
    do_req(1'b0, victim, '0, lat);
    chk("victim_refetch", n_miss, 1);

    // Reset in the middle of a fill
    resp_delay = 50;
    @(posedge clk); #1;
    mem_read = 1'b1; mem_address = 16'h0040;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pmem_read) begin seen = 1'b1; break; end
    end
    chk("abort_fill_seen", seen, 1);
    @(posedge clk); #1 rst = 1'b1; mem_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_outputs", {pmem_read, pmem_write, eviction, mem_resp}, 0);
    @(posedge clk); #1 rst = 1'b0; resp_delay = 0;
    clear_mon();
    do_req(1'b0, 16'h0000, '0, lat);
    chk("post_rst_miss", n_miss, 1);
    chk("post_rst_fill", n_pr_start, 1);

    // Slow memory: request must hold steady
    resp_delay = 20;
    clear_mon();
    do_req(1'b0, 16'h0050, '0, lat);
    chk("slow_pr_cycles", n_pr_cyc, 21);
    chk("slow_stable", n_stab, 0);
    chk("slow_resp_once", n_resp, 1);
    chk("slow_lat", lat, 24);
    resp_delay = 0;

    repeat (3) @(posedge clk);
    chk("inc_exclusive", n_both, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
